// File: rtl/d_ff.sv
// d_ff: positive-edge D register with asynchronous active-high reset.
// All WIDTH bits are captured together on the rising clk edge; rst forces
// RESET_VALUE immediately and wins over a coincident clock edge.
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on the rising edge; reset is sensed asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed test of d_ff at WIDTH=1 and WIDTH=8 (RESET_VALUE=8'hA5).
// A behavioural model tracks "last d seen before a rising edge, or the reset
// value while/after reset" and is compared at every falling edge, alongside
// hand-computed literal checks at the points of interest.
`timescale 1ns/1ps
module tb_d_ff;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst1 = 1'b0, rst8 = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       q1;
  logic [7:0] q8;

  // model state
  logic       exp1, exp8_valid;
  logic [7:0] exp8;
  logic       model_on = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  d_ff #(.WIDTH(1)) u1 (.clk(clk), .rst(rst1), .d(d1), .q(q1));
  d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u8 (.clk(clk), .rst(rst8), .d(d8), .q(q8));

  task automatic chk1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model update for a rising edge: the value sampled is d just before the
  // edge, unless reset is high at that moment.
  task automatic rise();
    exp1 = rst1 ? 1'b0 : d1;
    exp8 = rst8 ? RV8  : d8;
    clk  = 1'b1;
    model_on = 1'b1;
  endtask

  task automatic fall();
    clk = 1'b0;
  endtask

  task automatic set_rst1(input logic v);
    rst1 = v;
    if (v) exp1 = 1'b0;
  endtask

  task automatic set_rst8(input logic v);
    rst8 = v;
    if (v) exp8 = RV8;
  endtask

  // Compare process: a falling edge must never move q, so q must still
  // equal the model there.
  always @(negedge clk) begin
    if (model_on) begin
      #0;
      chk1("model_q1_negedge", q1, exp1);
      chk8("model_q8_negedge", q8, exp8);
    end
  end

  logic [7:0] vec [6] = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h01};

  initial begin
    // 1. capture: d=1 at t=0, rise at t=5, check at t=6
    d1 = 1'b1; d8 = 8'h11;
    #5 rise();
    #1 chk1("capture_t6", q1, 1'b1);
    chk8("capture8_t6", q8, 8'h11);
    // 2. hold while clk high with d changing
    #1 d1 = 1'b0; d8 = 8'hEE;
    #1 chk1("hold_high_t8", q1, 1'b1);
    chk8("hold_high8_t8", q8, 8'h11);
    #1 chk1("hold_high_t9", q1, 1'b1);
    // 3. falling edge at t=9 does not capture
    fall();
    #5 chk1("falling_no_capture_t14", q1, 1'b1);
    chk8("falling_no_capture8_t14", q8, 8'h11);
    // 4. next rising edge at t=14 captures d=0
    rise();
    #2 chk1("next_rise_t16", q1, 1'b0);
    chk8("next_rise8_t16", q8, 8'hEE);
    #3 fall();
    // load q1=1 for the reset test
    d1 = 1'b1;
    #5 rise();
    #1 chk1("preload_one", q1, 1'b1);
    #4 fall();
    // 5. async reset mid-cycle, clk held low
    #2 set_rst1(1'b1);
    #1 chk1("async_reset_no_clk", q1, 1'b0);
    #1 d1 = 1'b1; set_rst1(1'b0);
    #1 chk1("release_holds", q1, 1'b0);
    #1 chk1("release_holds2", q1, 1'b0);
    #1 rise();
    #1 chk1("after_release_capture", q1, 1'b1);
    #4 fall();
    // 6. reset dominance, 8-bit
    d8 = 8'h3C;
    #2 set_rst8(1'b1);
    #1 chk8("rst8_async", q8, RV8);
    #2 rise();
    #1 chk8("rst8_edge1", q8, RV8);
    #4 fall();
    #5 rise();
    #1 chk8("rst8_edge2", q8, RV8);
    #4 fall();
    #2 set_rst8(1'b0);
    #1 chk8("rst8_release_holds", q8, RV8);
    #2 rise();
    #1 chk8("rst8_after_release", q8, 8'h3C);
    // reset asserted at the same instant as a rising edge
    #4 fall();
    d8 = 8'hC3;
    #5 rst8 = 1'b1; exp8 = RV8; clk = 1'b1;
    #1 chk8("rst8_coincident_edge", q8, RV8);
    #4 fall();
    #2 set_rst8(1'b0);
    // directed vectors with d toggling while clk is high and low
    for (int i = 0; i < 6; i++) begin
      d8 = vec[i];
      d1 = vec[i][0];
      #3 rise();
      #1 chk8("vec_capture", q8, vec[i]);
      chk1("vec_capture1", q1, vec[i][0]);
      d8 = ~vec[i]; d1 = ~vec[i][0];
      #1 chk8("vec_hold_high", q8, vec[i]);
      #3 fall();
      #1 d8 = 8'h99;
      #1 chk8("vec_hold_low", q8, vec[i]);
    end
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
